// File: rtl/lcd_rx_model.sv
// Receiver model for the HD44780-style 8-bit LCD write bus: decodes transfers,
// keeps a 2x16 DDRAM shadow with cursor tracking, emulates busy and flags protocol errors.
module lcd_rx_model #(
  parameter int MIN_E_HIGH   = 12,
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 80000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] data,
  input  logic [4:0] rd_idx_i,
  output logic [7:0] rd_char_o,
  output logic       char_valid_o,
  output logic [7:0] char_o,
  output logic [4:0] char_idx_o,
  output logic       cmd_valid_o,
  output logic [7:0] cmd_o,
  output logic [4:0] cursor_o,
  output logic       display_on_o,
  output logic       busy_o,
  output logic [2:0] err_o
);

  localparam int EW   = $clog2(MIN_E_HIGH + 1);
  localparam int BMAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int BW   = $clog2(BMAX + 1);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CLEAR,
    OP_HOME,
    OP_ENTRY,
    OP_DISP,
    OP_DDRAM
  } op_e;

  logic [7:0]    shadow [32];
  logic          e_r, e_prev;
  logic [EW-1:0] e_cnt;
  logic          pend, pend_rs;
  logic [7:0]    pend_data;
  logic          inc_mode;
  logic          busy_q;
  logic [BW-1:0] busy_cnt;
  logic          fill_act, fill_busy;
  logic [4:0]    fill_idx;
  logic          e_fall;
  logic          ddram_ok;
  op_e           op;

  assign e_fall   = e_prev & ~e_r;
  assign ddram_ok = (pend_data[5:4] == 2'b00);
  assign busy_o   = busy_q | fill_busy;

  // Instruction class is decided by the highest set bit of the byte.
  always_comb begin
    op = OP_NONE;
    casez (pend_data)
      8'b1???_????: op = OP_DDRAM;
      8'b0000_1???: op = OP_DISP;
      8'b0000_01??: op = OP_ENTRY;
      8'b0000_001?: op = OP_HOME;
      8'b0000_0001: op = OP_CLEAR;
      default:      op = OP_NONE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_r          <= 1'b0;
      e_prev       <= 1'b0;
      e_cnt        <= '0;
      pend         <= 1'b0;
      pend_rs      <= 1'b0;
      pend_data    <= '0;
      char_valid_o <= 1'b0;
      char_o       <= '0;
      char_idx_o   <= '0;
      cmd_valid_o  <= 1'b0;
      cmd_o        <= '0;
      cursor_o     <= '0;
      display_on_o <= 1'b0;
      err_o        <= '0;
      rd_char_o    <= 8'h20;
      inc_mode     <= 1'b1;
      busy_q       <= 1'b0;
      busy_cnt     <= '0;
      fill_act     <= 1'b1;
      fill_busy    <= 1'b0;
      fill_idx     <= '0;
    end else begin
      e_r          <= lcd_e;
      e_prev       <= e_r;
      rd_char_o    <= shadow[rd_idx_i];
      char_valid_o <= 1'b0;
      cmd_valid_o  <= 1'b0;
      pend         <= 1'b0;

      if (e_r) begin
        if (e_cnt != EW'(MIN_E_HIGH)) e_cnt <= e_cnt + 1'b1;
      end else begin
        e_cnt <= '0;
      end

      if (e_fall) begin
        if (e_cnt < EW'(MIN_E_HIGH)) begin
          err_o[0] <= 1'b1;
        end else if (!lcd_rw) begin
          pend      <= 1'b1;
          pend_rs   <= lcd_rs;
          pend_data <= data;
        end
      end

      if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
      else                busy_q   <= 1'b0;

      fill_busy <= fill_act && (fill_idx != 5'd31);
      if (fill_act) begin
        shadow[fill_idx] <= 8'h20;
        fill_idx         <= fill_idx + 1'b1;
        if (fill_idx == 5'd31) fill_act <= 1'b0;
      end

      // Action cycle: later loads here override the countdown above.
      if (pend) begin
        if (busy_o) begin
          err_o[1] <= 1'b1;
        end else if (pend_rs) begin
          shadow[cursor_o] <= pend_data;
          char_valid_o     <= 1'b1;
          char_o           <= pend_data;
          char_idx_o       <= cursor_o;
          cursor_o         <= inc_mode ? cursor_o + 1'b1 : cursor_o - 1'b1;
          busy_q           <= 1'b1;
          busy_cnt         <= BW'(BUSY_CYCLES - 1);
        end else begin
          cmd_valid_o <= 1'b1;
          cmd_o       <= pend_data;
          busy_q      <= 1'b1;
          busy_cnt    <= BW'(BUSY_CYCLES - 1);
          case (op)
            OP_CLEAR: begin
              fill_act <= 1'b1;
              fill_idx <= '0;
              cursor_o <= '0;
              inc_mode <= 1'b1;
              busy_cnt <= BW'(CLEAR_CYCLES - 1);
            end
            OP_HOME: begin
              cursor_o <= '0;
              busy_cnt <= BW'(CLEAR_CYCLES - 1);
            end
            OP_ENTRY: inc_mode     <= pend_data[1];
            OP_DISP:  display_on_o <= pend_data[2];
            OP_DDRAM: begin
              if (ddram_ok) cursor_o <= {pend_data[6], pend_data[3:0]};
              else          err_o[2] <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_rx_model.sv
// Scoreboard bench for lcd_rx_model: directed plan followed by randomized transfers
// checked against a behavioural DDRAM/cursor/busy model.
module tb_lcd_rx_model;

  localparam int MINE = 12;
  localparam int BUSYC = 40;
  localparam int CLRC = 120;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [7:0] data = 8'h00;
  logic [4:0] rd_idx = 5'd0;
  logic [7:0] rd_char;
  logic       char_valid;
  logic [7:0] char_val;
  logic [4:0] char_idx;
  logic       cmd_valid;
  logic [7:0] cmd_val;
  logic [4:0] cursor;
  logic       display_on;
  logic       busy;
  logic [2:0] err;

  lcd_rx_model #(
    .MIN_E_HIGH  (MINE),
    .BUSY_CYCLES (BUSYC),
    .CLEAR_CYCLES(CLRC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .lcd_e       (lcd_e),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .data        (data),
    .rd_idx_i    (rd_idx),
    .rd_char_o   (rd_char),
    .char_valid_o(char_valid),
    .char_o      (char_val),
    .char_idx_o  (char_idx),
    .cmd_valid_o (cmd_valid),
    .cmd_o       (cmd_val),
    .cursor_o    (cursor),
    .display_on_o(display_on),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_char;
    logic [7:0] val;
    logic [4:0] idx;
  } ev_t;

  ev_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_sh [32];
  int         m_cur = 0;
  bit         m_inc = 1'b1;
  bit         m_disp = 1'b0;
  logic [2:0] m_err = 3'b000;
  longint     busy_until = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (char_valid || cmd_valid)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {30'b0, char_valid, cmd_valid}, 32'd0);
      end else begin
        ev_t e;
        e = q.pop_front();
        check("pulse_kind", 32'(char_valid), 32'(e.is_char));
        if (e.is_char) begin
          check("char_o", 32'(char_val), 32'(e.val));
          check("char_idx_o", 32'(char_idx), 32'(e.idx));
        end else begin
          check("cmd_o", 32'(cmd_val), 32'(e.val));
        end
      end
    end
  end

  // Reference model, applied when E drops; the DUT acts about three cycles later.
  task automatic model(input bit rs, input bit rw, input logic [7:0] d, input int eh);
    longint act;
    int a;
    act = cyc + 3;
    if (eh < MINE) m_err[0] = 1'b1;
    else if (rw) begin end
    else if (act <= busy_until) m_err[1] = 1'b1;
    else if (rs) begin
      m_sh[m_cur] = d;
      q.push_back('{1'b1, d, 5'(m_cur)});
      m_cur = m_inc ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
      busy_until = act + BUSYC;
    end else begin
      q.push_back('{1'b0, d, 5'd0});
      busy_until = act + BUSYC;
      if (d == 8'd1) begin
        for (int i = 0; i < 32; i++) m_sh[i] = 8'h20;
        m_cur = 0;
        m_inc = 1'b1;
        busy_until = act + CLRC;
      end else if (d == 8'd2 || d == 8'd3) begin
        m_cur = 0;
        busy_until = act + CLRC;
      end else if (d >= 8'd4 && d < 8'd8) begin
        m_inc = d[1];
      end else if (d >= 8'd8 && d < 8'd16) begin
        m_disp = d[2];
      end else if (d >= 8'd128) begin
        a = int'(d) - 128;
        if (a < 16) m_cur = a;
        else if (a >= 64 && a < 80) m_cur = 16 + a - 64;
        else m_err[2] = 1'b1;
      end
    end
  endtask

  task automatic send(input bit rs, input bit rw, input logic [7:0] d, input int eh);
    @(negedge clk);
    lcd_rs = rs;
    lcd_rw = rw;
    data   = d;
    lcd_e  = 1'b1;
    repeat (eh) @(negedge clk);
    lcd_e = 1'b0;
    model(rs, rw, d, eh);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_free();
    while (cyc <= busy_until + 3) @(negedge clk);
  endtask

  task automatic wr(input bit rs, input logic [7:0] d);
    send(rs, 1'b0, d, 15);
    settle();
    wait_free();
  endtask

  task automatic read_chk(input int idx);
    @(negedge clk);
    rd_idx = 5'(idx);
    @(negedge clk);
    check("rd_char_o", 32'(rd_char), 32'(m_sh[idx]));
  endtask

  task automatic measure_busy(input string nm, input int exp);
    int n = 0;
    int k = 0;
    while (!busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    while (busy && n < exp + 100) begin
      n++;
      @(negedge clk);
    end
    check(nm, 32'(n), 32'(exp));
  endtask

  task automatic check_state();
    check("cursor_o", 32'(cursor), 32'(m_cur));
    check("display_on_o", 32'(display_on), 32'(m_disp));
    check("err_o", 32'(err), 32'(m_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) m_sh[i] = 8'h20;
    repeat (3) @(negedge clk);
    check("rst_rd_char", 32'(rd_char), 32'h20);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", {30'b0, char_valid, cmd_valid}, 32'd0);
    check_state();

    rst = 1'b0;
    busy_until = cyc + 34;
    repeat (40) @(negedge clk);
    check("fill_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 32; i++) read_chk(i);

    // 0x80, "50"
    wr(1'b0, 8'h80);
    send(1'b1, 1'b0, 8'h35, 15);
    measure_busy("busy_len_data", BUSYC);
    wait_free();
    wr(1'b1, 8'h30);
    check_state();
    read_chk(0);
    read_chk(1);

    // Row-crossing writes at 15 and 16
    wr(1'b0, 8'h8F);
    wr(1'b1, 8'h41);
    wr(1'b1, 8'h42);
    check_state();
    read_chk(15);
    read_chk(16);

    // Decrement mode wraps 0 -> 0x1F
    wr(1'b0, 8'h04);
    wr(1'b0, 8'h80);
    wr(1'b1, 8'h58);
    check_state();
    read_chk(0);
    wr(1'b0, 8'h0C);
    check_state();

    // Short E pulse
    send(1'b1, 1'b0, 8'h77, 5);
    settle();
    repeat (10) @(negedge clk);
    check_state();
    read_chk(31);

    // Write while busy
    send(1'b1, 1'b0, 8'h61, 15);
    settle();
    send(1'b1, 1'b0, 8'h62, 15);
    settle();
    wait_free();
    check_state();
    read_chk(31);
    read_chk(30);

    // Read transfer is ignored
    send(1'b1, 1'b1, 8'h55, 15);
    settle();
    check_state();

    // Illegal DDRAM address then clear
    wr(1'b0, 8'hA0);
    check_state();
    send(1'b0, 1'b0, 8'h01, 15);
    measure_busy("busy_len_clear", CLRC);
    wait_free();
    check_state();
    for (int i = 0; i < 32; i++) read_chk(i);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      bit rs;
      bit rw;
      int eh;
      logic [7:0] d;
      rs = ($urandom_range(0, 1) == 1);
      rw = ($urandom_range(0, 9) == 0);
      eh = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, MINE - 1)) : int'($urandom_range(MINE, 20));
      d  = 8'($urandom);
      if (!rs && $urandom_range(0, 2) == 0) d = {1'b1, 1'($urandom), 2'b00, 4'($urandom)};
      send(rs, rw, d, eh);
      settle();
      if (!(busy_until > cyc + 30 && $urandom_range(0, 3) == 0)) begin
        wait_free();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_free();
    check_state();
    for (int i = 0; i < 32; i++) read_chk(i);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_rx_model.md
Name: lcd_rx_model

Overview:
- Synthesizable receiver for the HD44780-style 8-bit write bus that drives the 2x16 character LCD (E, RS, RW, DATA[7:0]).
- Decodes each write transfer into an instruction or a character write and maintains a 32-entry DDRAM shadow with cursor tracking.
- Emulates the controller busy window and flags protocol violations.
- Sits on the LCD pins inside on-chip loopback and self-check builds. Characters can be read back from the shadow for comparison against the expected sum and count strings.

Parameters:
- MIN_E_HIGH, 12, minimum clk_i cycles lcd_e must stay high for a valid transfer.
- BUSY_CYCLES, 2000, busy window after any accepted non-clear or non-home transfer.
- CLEAR_CYCLES, 80000, busy window after clear or home. Must be >= 32.

Ports:
- clk_i  in  1  system clock (CLOCK_50 domain)
- rst_i  in  1  synchronous reset, active-high
- lcd_e  in  1  enable strobe; transfer latched on its falling edge
- lcd_rs  in  1  0 = instruction, 1 = data
- lcd_rw  in  1  0 = write, 1 = read
- data  in  8  bus data
- rd_idx_i  in  5  shadow read index: bit4 = row, bits3:0 = column
- rd_char_o  out  8  shadow character at rd_idx_i, registered, 1-cycle latency
- char_valid_o  out  1  1-cycle pulse on each accepted data write
- char_o  out  8  character written; valid with char_valid_o
- char_idx_o  out  5  shadow index written; valid with char_valid_o
- cmd_valid_o  out  1  1-cycle pulse on each accepted instruction
- cmd_o  out  8  instruction byte; valid with cmd_valid_o
- cursor_o  out  5  current address counter as shadow index
- display_on_o  out  1  D bit from last display-control instruction
- busy_o  out  1  emulated busy flag
- err_o  out  3  sticky flags: [0] short E pulse, [1] write while busy, [2] illegal DDRAM address. Cleared only by reset.

Behaviour:
- Reset values (sync, rst_i high at clk_i edge):
  - all pulse outputs = 0; cmd_o = 0; char_o = 0; char_idx_o = 0; cursor_o = 0
  - display_on_o = 0; busy_o = 0; err_o = 0; rd_char_o = 0x20
  - increment mode = 1; all 32 shadow entries = 0x20
  - the shadow fill runs one entry per cycle over 32 cycles after reset release; busy_o = 1 during the fill
- Inputs are in the clk_i domain. lcd_e is registered once; a falling edge is prev = 1 and cur = 0.
- E-high counter:
  - counts cycles while lcd_e = 1 and saturates at MIN_E_HIGH.
  - on the falling edge: if count < MIN_E_HIGH, set err_o[0] and drop the transfer.
- lcd_rw = 1 at the falling edge: transfer ignored, no error.
- Transfers are acted on one cycle after the registered falling edge. Pulses last exactly one cycle.
- Any accepted write while busy_o = 1: set err_o[1] and drop the transfer (no shadow or state change).
- Instruction decode (RS = 0), by highest set bit:
  - 0x01 clear: fill shadow with 0x20 over 32 cycles, address = 0, increment mode = 1. Busy = CLEAR_CYCLES.
  - 0x02–0x03 home: address = 0, shadow unchanged. Busy = CLEAR_CYCLES.
  - 0x04–0x07 entry mode: increment mode = bit1.
  - 0x08–0x0F display control: display_on_o = bit2.
  - 0x10–0x3F cursor shift and function set: no state change.
  - 0x40–0x7F CGRAM address: no state change.
  - 0x80–0xFF DDRAM address A = data[6:0]:
    - A in 0x00–0x0F or 0x40–0x4F: cursor = {A[6], A[3:0]}.
    - any other A: set err_o[2]; cursor unchanged.
  - cmd_valid_o pulses for every accepted instruction, including illegal-address ones. Busy = BUSY_CYCLES unless stated above.
- Data write (RS = 1):
  - shadow[cursor] = data; char_valid_o pulses with char_idx_o = old cursor.
  - cursor then moves: increment 0x0F→0x10 and 0x1F→0x00; decrement 0x00→0x1F and 0x10→0x0F.
  - busy = BUSY_CYCLES.
- Busy timing:
  - the busy down-counter loads on the action cycle.
  - busy_o is high from the cycle after the action through exactly N cycles, then low.
- Read port:
  - rd_char_o = shadow[rd_idx_i] registered.
  - a same-cycle write to the same index returns the old value.
- Reset mid-transfer or mid-clear: restart the reset fill; any pending transfer is lost.

Test Plan:
- Release reset, wait 32 cycles, read all 32 indices -> every rd_char_o = 0x20, busy_o = 0, err_o = 0.
- Send 0x80, then data 0x35 0x30 (E high 15 cycles, gaps > BUSY_CYCLES) -> cmd_o = 0x80; char_idx_o = 0 then 1; shadow[0..1] = "50"; cursor_o = 2.
- Send 0x8F, then 2 data bytes 0x41 0x42 -> writes land at index 15 and 16; cursor_o = 17.
- Send 0x04, then 0x80, then data 0x58 -> shadow[0] = 'X'; cursor_o = 0x1F.
- Send a 5-cycle E pulse -> err_o[0] set, no pulses. Send a second write 10 cycles after an accepted one -> err_o[1] set and the shadow is unchanged.
- Send 0xA0 -> err_o[2] set, cmd_valid_o pulses, cursor unchanged. Then send 0x01 -> busy_o high for CLEAR_CYCLES and all entries = 0x20.
